// File: rtl/traffic_sensor_model.sv
// -----------------------------------------------------------------------------
// traffic_sensor_model
//
// Closed-loop vehicle/sensor model placed between the LFSR arrival source and
// the traffic light controller. Each street keeps a saturating queue of
// waiting cars. Cars leave one at a time while the street is green, spaced by
// DEP_GAP idle cycles. The sensor outputs Ta/Tb report a non-empty queue.
// Illegal lamp combinations are latched in sticky error flags.
//
// Parameters
//   QW       queue counter width; the queue saturates at 2^QW-1
//   DEP_GAP  idle cycles between departures under green (1..15)
//
// Ports
//   clk                 rising-edge clock
//   reset               asynchronous active-low reset
//   arr_a, arr_b        one-cycle car-arrival pulses
//   Ra, Ya, Ga          street A lamps from the controller
//   Rb, Yb, Gb          street B lamps from the controller
//   Ta, Tb              sensor outputs: queue non-empty
//   cnt_a, cnt_b        current queue depth
//   dep_a, dep_b        one-cycle pulse per departing car
//   ovf_a, ovf_b        sticky: an arrival was dropped at a full queue
//   err_conflict        sticky: both streets non-red in the same cycle
//   err_encoding        sticky: a street did not have exactly one lamp lit
// -----------------------------------------------------------------------------
module traffic_sensor_model #(
    parameter int QW      = 4,
    parameter int DEP_GAP = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          arr_a,
    input  logic          arr_b,
    input  logic          Ra,
    input  logic          Ya,
    input  logic          Ga,
    input  logic          Rb,
    input  logic          Yb,
    input  logic          Gb,
    output logic          Ta,
    output logic          Tb,
    output logic [QW-1:0] cnt_a,
    output logic [QW-1:0] cnt_b,
    output logic          dep_a,
    output logic          dep_b,
    output logic          ovf_a,
    output logic          ovf_b,
    output logic          err_conflict,
    output logic          err_encoding
);

    localparam logic [3:0]    LP_GAP  = 4'(DEP_GAP);
    localparam logic [QW-1:0] LP_MAX  = '1;
    localparam logic [QW-1:0] LP_ONE  = QW'(1);
    localparam logic [QW-1:0] LP_ZERO = '0;

    // Street index 0 = A, 1 = B.
    logic [1:0]    w_arr;
    logic [1:0]    w_green;
    logic [QW-1:0] w_cnt [2];
    logic [1:0]    w_dep;
    logic [1:0]    w_ovf;

    assign w_arr   = {arr_b, arr_a};
    assign w_green = {Gb, Ga};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_street
            logic [QW-1:0] r_cnt;
            logic [3:0]    r_gap;
            logic          r_dep;
            logic          r_ovf;
            logic          w_depart;

            // A car leaves when the street is green, the spacing gap has run
            // out and someone is actually waiting. Gating on r_cnt also keeps
            // the decrement from ever wrapping below zero.
            assign w_depart = w_green[gi] && (r_gap == 4'd0) && (r_cnt != LP_ZERO);

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_cnt <= LP_ZERO;
                    r_gap <= LP_GAP;
                    r_dep <= 1'b0;
                    r_ovf <= 1'b0;
                end else begin
                    r_dep <= w_depart;

                    // Yellow counts as not green: the gap reloads so the next
                    // green phase starts with a full DEP_GAP wait.
                    if (!w_green[gi]) begin
                        r_gap <= LP_GAP;
                    end else if (r_gap != 4'd0) begin
                        r_gap <= r_gap - 4'd1;
                    end else if (r_cnt != LP_ZERO) begin
                        r_gap <= LP_GAP;
                    end
                    // gap == 0 with an empty queue holds at 0, so a car that
                    // arrives later departs on the very next edge.

                    // Arrival and departure in the same cycle cancel; the
                    // arrival is absorbed and never counts as an overflow.
                    if (w_arr[gi] && !w_depart) begin
                        if (r_cnt == LP_MAX) begin
                            r_ovf <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + LP_ONE;
                        end
                    end else if (w_depart && !w_arr[gi]) begin
                        r_cnt <= r_cnt - LP_ONE;
                    end
                end
            end

            assign w_cnt[gi] = r_cnt;
            assign w_dep[gi] = r_dep;
            assign w_ovf[gi] = r_ovf;
        end
    endgenerate

    // Lamp checks: each street must show exactly one lamp, and at least one
    // street must be red in every cycle.
    logic [1:0] w_lit_a;
    logic [1:0] w_lit_b;
    logic       w_bad_enc;
    logic       w_bad_conf;
    logic       r_err_conflict;
    logic       r_err_encoding;

    assign w_lit_a    = {1'b0, Ra} + {1'b0, Ya} + {1'b0, Ga};
    assign w_lit_b    = {1'b0, Rb} + {1'b0, Yb} + {1'b0, Gb};
    assign w_bad_enc  = (w_lit_a != 2'd1) || (w_lit_b != 2'd1);
    assign w_bad_conf = !Ra && !Rb;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_err_conflict <= 1'b0;
            r_err_encoding <= 1'b0;
        end else begin
            r_err_conflict <= r_err_conflict | w_bad_conf;
            r_err_encoding <= r_err_encoding | w_bad_enc;
        end
    end

    // All outputs come from registers only; no input reaches an output
    // combinationally.
    assign cnt_a        = w_cnt[0];
    assign cnt_b        = w_cnt[1];
    assign Ta           = (w_cnt[0] != LP_ZERO);
    assign Tb           = (w_cnt[1] != LP_ZERO);
    assign dep_a        = w_dep[0];
    assign dep_b        = w_dep[1];
    assign ovf_a        = w_ovf[0];
    assign ovf_b        = w_ovf[1];
    assign err_conflict = r_err_conflict;
    assign err_encoding = r_err_encoding;

endmodule

// File: tb/tb_traffic_sensor_model.sv
// -----------------------------------------------------------------------------
// tb_traffic_sensor_model
//
// Directed bench for traffic_sensor_model (QW = 4, DEP_GAP = 2). The stimulus
// process pushes hand-computed expected output snapshots into a queue; a
// monitor pops and compares them. Departure pulses are checked by a second
// monitor against a queue of expected post-departure queue depths.
// -----------------------------------------------------------------------------
module tb_traffic_sensor_model;

    logic       clk;
    logic       reset;
    logic       arr_a, arr_b;
    logic       Ra, Ya, Ga, Rb, Yb, Gb;
    logic       Ta, Tb;
    logic [3:0] cnt_a, cnt_b;
    logic       dep_a, dep_b;
    logic       ovf_a, ovf_b;
    logic       err_conflict, err_encoding;

    int num_checks = 0;
    int num_errors = 0;

    traffic_sensor_model #(.QW(4), .DEP_GAP(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .arr_a        (arr_a),
        .arr_b        (arr_b),
        .Ra           (Ra),
        .Ya           (Ya),
        .Ga           (Ga),
        .Rb           (Rb),
        .Yb           (Yb),
        .Gb           (Gb),
        .Ta           (Ta),
        .Tb           (Tb),
        .cnt_a        (cnt_a),
        .cnt_b        (cnt_b),
        .dep_a        (dep_a),
        .dep_b        (dep_b),
        .ovf_a        (ovf_a),
        .ovf_b        (ovf_b),
        .err_conflict (err_conflict),
        .err_encoding (err_encoding)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic [3:0] ca;
        logic [3:0] cb;
        logic       da;
        logic       db;
        logic       oa;
        logic       ob;
        logic       ec;
        logic       ee;
    } snap_t;

    snap_t      snap_q[$];
    logic [3:0] dep_q_a[$];
    logic [3:0] dep_q_b[$];
    event       snap_ev;

    // Hand-tracked expected state, updated by the stimulus.
    logic [3:0] e_ca, e_cb;
    logic       e_oa, e_ob, e_ec, e_ee;

    task automatic clear_exp();
        e_ca = 4'd0; e_cb = 4'd0;
        e_oa = 1'b0; e_ob = 1'b0; e_ec = 1'b0; e_ee = 1'b0;
    endtask

    task automatic snap(input string tag, input logic da, input logic db);
        snap_t s;
        s.tag = tag;
        s.ca = e_ca; s.cb = e_cb;
        s.da = da;   s.db = db;
        s.oa = e_oa; s.ob = e_ob;
        s.ec = e_ec; s.ee = e_ee;
        snap_q.push_back(s);
        -> snap_ev;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic lamps(input logic ra, ya, ga, rb, yb, gb);
        Ra = ra; Ya = ya; Ga = ga; Rb = rb; Yb = yb; Gb = gb;
    endtask

    // Reset asserted away from the clock edge; outputs must clear at once.
    task automatic do_reset(input string tag);
        @(negedge clk);
        #2 reset = 1'b0;
        #1 clear_exp();
        snap(tag, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        tick();
        snap({tag, "_released"}, 1'b0, 1'b0);
    endtask

    // Snapshot monitor.
    initial begin
        snap_t      s;
        logic [15:0] act, exp_v;
        forever begin
            @(snap_ev);
            while (snap_q.size() > 0) begin
                s = snap_q.pop_front();
                act   = {Ta, Tb, cnt_a, cnt_b, dep_a, dep_b, ovf_a, ovf_b,
                         err_conflict, err_encoding};
                exp_v = {(s.ca != 4'd0), (s.cb != 4'd0), s.ca, s.cb, s.da, s.db,
                         s.oa, s.ob, s.ec, s.ee};
                num_checks++;
                if (act !== exp_v) begin
                    num_errors++;
                    $display("FAIL %s: got Ta=%b Tb=%b cnt_a=%0d cnt_b=%0d dep=%b%b ovf=%b%b errc=%b erre=%b, want Ta=%b Tb=%b cnt_a=%0d cnt_b=%0d dep=%b%b ovf=%b%b errc=%b erre=%b",
                             s.tag, Ta, Tb, cnt_a, cnt_b, dep_a, dep_b, ovf_a, ovf_b,
                             err_conflict, err_encoding,
                             (s.ca != 4'd0), (s.cb != 4'd0), s.ca, s.cb, s.da, s.db,
                             s.oa, s.ob, s.ec, s.ee);
                end else begin
                    $display("ok   %s: cnt_a=%0d cnt_b=%0d dep=%b%b ovf=%b%b errc=%b erre=%b",
                             s.tag, cnt_a, cnt_b, dep_a, dep_b, ovf_a, ovf_b,
                             err_conflict, err_encoding);
                end
            end
        end
    end

    // Departure monitor: every dep pulse must match an expected departure.
    always @(negedge clk) begin
        if (reset) begin
            if (dep_a) begin
                num_checks++;
                if (dep_q_a.size() == 0) begin
                    num_errors++;
                    $display("FAIL dep_a_unexpected: got dep_a=1 cnt_a=%0d, want no departure", cnt_a);
                end else begin
                    logic [3:0] want;
                    want = dep_q_a.pop_front();
                    if (cnt_a !== want) begin
                        num_errors++;
                        $display("FAIL dep_a_depth: got cnt_a=%0d, want %0d", cnt_a, want);
                    end else begin
                        $display("ok   dep_a: cnt_a=%0d", cnt_a);
                    end
                end
            end
            if (dep_b) begin
                num_checks++;
                if (dep_q_b.size() == 0) begin
                    num_errors++;
                    $display("FAIL dep_b_unexpected: got dep_b=1 cnt_b=%0d, want no departure", cnt_b);
                end else begin
                    logic [3:0] want;
                    want = dep_q_b.pop_front();
                    if (cnt_b !== want) begin
                        num_errors++;
                        $display("FAIL dep_b_depth: got cnt_b=%0d, want %0d", cnt_b, want);
                    end else begin
                        $display("ok   dep_b: cnt_b=%0d", cnt_b);
                    end
                end
            end
        end
    end

    // Watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: got no end of stimulus, want finish before 200000 ns");
        $fatal(1, "watchdog expired");
    end

    // Drain timeline after green is first sampled at edge 0.
    logic [3:0] drain_cnt [10] = '{4'd3, 4'd3, 4'd2, 4'd2, 4'd2, 4'd1, 4'd1, 4'd1, 4'd0, 4'd0};
    logic       drain_dep [10] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

    initial begin
        reset = 1'b0;
        arr_a = 1'b0;
        arr_b = 1'b0;
        lamps(1, 0, 0, 1, 0, 0);
        clear_exp();

        // Power-on reset
        repeat (3) tick();
        snap("reset_state", 1'b0, 1'b0);
        reset = 1'b1;
        tick();
        snap("after_release", 1'b0, 1'b0);

        // Queue build on street A with both streets red
        arr_a = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            e_ca = 4'(i);
            snap($sformatf("build_%0d", i), 1'b0, 1'b0);
        end
        arr_a = 1'b0;
        tick();
        snap("build_hold", 1'b0, 1'b0);

        // Drain: green on A first sampled at edge 0
        lamps(0, 0, 1, 1, 0, 0);
        dep_q_a.push_back(4'd2);
        dep_q_a.push_back(4'd1);
        dep_q_a.push_back(4'd0);
        for (int e = 0; e < 10; e++) begin
            tick();
            e_ca = drain_cnt[e];
            snap($sformatf("drain_edge%0d", e), drain_dep[e], 1'b0);
        end
        for (int e = 10; e < 13; e++) begin
            tick();
            snap($sformatf("drain_idle%0d", e), 1'b0, 1'b0);
        end

        // Arrival into an empty queue with gap already 0 leaves next edge
        dep_q_a.push_back(4'd0);
        arr_a = 1'b1;
        tick();
        arr_a = 1'b0;
        e_ca = 4'd1;
        snap("late_arrival", 1'b0, 1'b0);
        tick();
        e_ca = 4'd0;
        snap("late_departure", 1'b1, 1'b0);
        tick();
        snap("late_idle", 1'b0, 1'b0);

        // Simultaneous arrival and departure
        lamps(1, 0, 0, 1, 0, 0);
        arr_a = 1'b1;
        tick();
        e_ca = 4'd1;
        snap("sim_fill1", 1'b0, 1'b0);
        tick();
        e_ca = 4'd2;
        snap("sim_fill2", 1'b0, 1'b0);
        arr_a = 1'b0;
        lamps(0, 0, 1, 1, 0, 0);
        tick();
        snap("sim_green_k", 1'b0, 1'b0);
        tick();
        snap("sim_green_k1", 1'b0, 1'b0);
        arr_a = 1'b1;
        dep_q_a.push_back(4'd2);
        tick();
        snap("sim_coincident", 1'b1, 1'b0);
        arr_a = 1'b0;
        lamps(1, 0, 0, 1, 0, 0);
        tick();
        snap("sim_red_again", 1'b0, 1'b0);

        // Saturation from an empty queue
        do_reset("reset_pre_sat");
        arr_a = 1'b1;
        for (int i = 1; i <= 17; i++) begin
            tick();
            e_ca = (i > 15) ? 4'd15 : 4'(i);
            e_oa = (i >= 16);
            snap($sformatf("sat_%0d", i), 1'b0, 1'b0);
        end
        arr_a = 1'b0;
        repeat (2) begin
            tick();
            snap("sat_hold", 1'b0, 1'b0);
        end

        // Lamp checks with cnt_a = 5
        do_reset("reset_pre_lamp");
        arr_a = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tick();
            e_ca = 4'(i);
            snap($sformatf("lamp_fill_%0d", i), 1'b0, 1'b0);
        end
        arr_a = 1'b0;
        lamps(0, 0, 1, 0, 0, 1);
        tick();
        e_ec = 1'b1;
        snap("conflict_set", 1'b0, 1'b0);
        lamps(1, 0, 0, 1, 0, 0);
        tick();
        snap("conflict_sticky", 1'b0, 1'b0);
        lamps(1, 0, 1, 1, 0, 0);
        tick();
        e_ee = 1'b1;
        snap("encoding_set", 1'b0, 1'b0);
        lamps(1, 0, 0, 1, 0, 0);
        repeat (2) begin
            tick();
            snap("encoding_sticky", 1'b0, 1'b0);
        end

        // Asynchronous reset mid-run: cnt_a = 5, both error flags set
        do_reset("async_reset");

        // Street B queue and drain
        arr_b = 1'b1;
        tick();
        arr_b = 1'b0;
        e_cb = 4'd1;
        snap("b_arrival", 1'b0, 1'b0);
        lamps(1, 0, 0, 0, 0, 1);
        dep_q_b.push_back(4'd0);
        tick();
        snap("b_green_k", 1'b0, 1'b0);
        tick();
        snap("b_green_k1", 1'b0, 1'b0);
        tick();
        e_cb = 4'd0;
        snap("b_departure", 1'b0, 1'b1);
        tick();
        snap("b_idle", 1'b0, 1'b0);
        lamps(1, 0, 0, 1, 0, 0);
        repeat (2) tick();
        snap("final_state", 1'b0, 1'b0);

        // Every expected departure must have been observed
        #1;
        num_checks++;
        if ((dep_q_a.size() + dep_q_b.size()) != 0) begin
            num_errors++;
            $display("FAIL dep_pending: got %0d A and %0d B departures missing, want 0",
                     dep_q_a.size(), dep_q_b.size());
        end
        num_checks++;
        if (snap_q.size() != 0) begin
            num_errors++;
            $display("FAIL snap_pending: got %0d snapshots unchecked, want 0", snap_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
        $finish;
    end

endmodule
